indice_buffer_loader: RTL

Write-side and ownership controller for the ping-pong index double buffer (two dual-port banks A/B, each K*K/32 entries of clog2(K) bits). Accepts a valid/ready stream of column indices, up to two per beat. Fills one bank while the consumer (aggregation engine) drains the other. Hands completed blocks to the consumer in strict A, B, A, … order and routes the consumer's read addresses to the bank it owns.

---
 rtl/indice_buffer_loader_pkg.sv | 22 ++
 rtl/indice_buffer_loader_if.sv | 37 +++
 rtl/indice_buffer_loader_bank_ctrl.sv | 80 ++++++++
 rtl/indice_buffer_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/indice_buffer_loader_pkg.sv
// rtl/indice_buffer_loader_pkg.sv - bank state type and size derivations for the index double buffer
// Contents: bank_state_t (per-bank ownership state), K_DEFAULT and the
// DEPTH / ADDR_W / DATA_W derivations from the block size K.
package indice_pkg;

    typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_state_t;

    localparam int K_DEFAULT = 1024;

    function automatic int depthOf(input int k);
        return (k * k) / 32;
    endfunction

    function automatic int addrWOf(input int k);
        return $clog2(depthOf(k));
    endfunction

    function automatic int dataWOf(input int k);
        return $clog2(k);
    endfunction

endpackage

// File: rtl/indice_buffer_loader_if.sv
// rtl/indice_buffer_loader_if.sv - index stream, block offer and consumer address bundle
// Ports (slave = loader view):
//   in_valid/in_ready, in_data0/in_data1, in_keep, in_last : index stream
//   blk_valid/blk_ready, blk_bank, blk_len, blk_release     : block hand-off
//   cons_addr1/cons_addr2                                   : consumer read addresses
interface indice_buffer_loader_if #(
    parameter int K = indice_pkg::K_DEFAULT
);
    localparam int ADDR_W = indice_pkg::addrWOf(K);
    localparam int DATA_W = indice_pkg::dataWOf(K);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data0;
    logic [DATA_W-1:0] in_data1;
    logic [1:0]        in_keep;
    logic              in_last;
    logic              blk_valid;
    logic              blk_ready;
    logic              blk_bank;
    logic [ADDR_W:0]   blk_len;
    logic              blk_release;
    logic [ADDR_W-1:0] cons_addr1;
    logic [ADDR_W-1:0] cons_addr2;

    modport slave (
        input  in_valid, in_data0, in_data1, in_keep, in_last,
        input  blk_ready, blk_release, cons_addr1, cons_addr2,
        output in_ready, blk_valid, blk_bank, blk_len
    );

    modport master (
        output in_valid, in_data0, in_data1, in_keep, in_last,
        output blk_ready, blk_release, cons_addr1, cons_addr2,
        input  in_ready, blk_valid, blk_bank, blk_len
    );
endinterface

// File: rtl/indice_buffer_loader_bank_ctrl.sv
// rtl/indice_buffer_loader_bank_ctrl.sv - one bank's ownership state, latched length and port mux
// Inputs : startFill/setFull/take/relIn state events, lenIn latched on setFull,
//          wrEn/wrAddr/wrData from the write pipeline, consAddr from the consumer.
// Outputs: state, len, and the bank's two RAM ports (addr/data/wen).
module indice_bank_ctrl
    import indice_pkg::*;
#(
    parameter  int K      = K_DEFAULT,
    localparam int ADDR_W = addrWOf(K),
    localparam int DATA_W = dataWOf(K)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              startFill,
    input  logic              setFull,
    input  logic [ADDR_W:0]   lenIn,
    input  logic              take,
    input  logic              relIn,
    input  logic              wrEn1,
    input  logic              wrEn2,
    input  logic [ADDR_W-1:0] wrAddr1,
    input  logic [ADDR_W-1:0] wrAddr2,
    input  logic [DATA_W-1:0] wrData1,
    input  logic [DATA_W-1:0] wrData2,
    input  logic [ADDR_W-1:0] consAddr1,
    input  logic [ADDR_W-1:0] consAddr2,
    output bank_state_t       state,
    output logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              wen1,
    output logic              wen2
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            len   <= '0;
        end else begin
            case (state)
                EMPTY:   if (startFill) state <= FILL;
                FILL:    if (setFull) begin
                             state <= FULL;
                             len   <= lenIn;
                         end
                FULL:    if (take) state <= DRAIN;
                DRAIN:   if (relIn) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

    // The last beat's writes land one cycle after the bank has already gone
    // FULL, so a pending pipeline write takes priority over the state view.
    always_comb begin
        addr1 = '0;
        addr2 = '0;
        data1 = '0;
        data2 = '0;
        wen1  = 1'b0;
        wen2  = 1'b0;
        if (wrEn1) begin
            addr1 = wrAddr1;
            data1 = wrData1;
            wen1  = 1'b1;
        end else if (state == DRAIN) begin
            addr1 = consAddr1;
        end
        if (wrEn2) begin
            addr2 = wrAddr2;
            data2 = wrData2;
            wen2  = 1'b1;
        end else if (state == DRAIN) begin
            addr2 = consAddr2;
        end
    end

endmodule

// File: rtl/indice_buffer_loader.sv
// rtl/indice_buffer_loader.sv - fill/offer/drain controller for the ping-pong index buffer
// Ports: clk, rst_n (async active-low), bus (stream + block hand-off + consumer
//        addresses), addr/data/wen for ports 1/2 of banks A and B, err_overflow.
module indice_buffer_loader
    import indice_pkg::*;
#(
    parameter  int K      = K_DEFAULT,
    localparam int DEPTH  = depthOf(K),
    localparam int ADDR_W = addrWOf(K),
    localparam int DATA_W = dataWOf(K)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    indice_buffer_loader_if.slave   bus,
    output logic [ADDR_W-1:0]       addrA1,
    output logic [ADDR_W-1:0]       addrA2,
    output logic [ADDR_W-1:0]       addrB1,
    output logic [ADDR_W-1:0]       addrB2,
    output logic [DATA_W-1:0]       dataA1,
    output logic [DATA_W-1:0]       dataA2,
    output logic [DATA_W-1:0]       dataB1,
    output logic [DATA_W-1:0]       dataB2,
    output logic                    wenA1,
    output logic                    wenA2,
    output logic                    wenB1,
    output logic                    wenB2,
    output logic                    err_overflow
);

    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W + 2)'(DEPTH);

    bank_state_t       stateA, stateB;
    logic [ADDR_W:0]   lenA, lenB;
    logic              fillSel, offSel;
    logic [ADDR_W:0]   wrPtr;

    logic              pipeBeat, pipeBank, pipeWe1, pipeWe2;
    logic [ADDR_W-1:0] pipeAddr1, pipeAddr2;
    logic [DATA_W-1:0] pipeData1, pipeData2;

    logic              anyFill, beatTake, lastTake, one, two;
    logic              lane0Ok, lane1Ok, drop, take, relA, relB;
    logic [ADDR_W+1:0] ptrX, ptr1, cnt, sum;
    logic [ADDR_W:0]   nextPtr;

    assign anyFill  = (stateA == FILL) || (stateB == FILL);
    assign beatTake = bus.in_valid && anyFill;
    assign lastTake = beatTake && bus.in_last;
    assign bus.in_ready = anyFill;

    // keep 10 deliberately decodes as no entries
    assign two = (bus.in_keep == 2'b11);
    assign one = (bus.in_keep == 2'b01);

    assign ptrX    = {1'b0, wrPtr};
    assign ptr1    = ptrX + (ADDR_W + 2)'(1);
    assign cnt     = two ? (ADDR_W + 2)'(2) : (one ? (ADDR_W + 2)'(1) : '0);
    assign sum     = ptrX + cnt;
    assign nextPtr = (sum > DEPTH_X) ? DEPTH_X[ADDR_W:0] : sum[ADDR_W:0];
    assign lane0Ok = (one || two) && (ptrX < DEPTH_X);
    assign lane1Ok = two && (ptr1 < DEPTH_X);
    assign drop    = ((one || two) && !lane0Ok) || (two && !lane1Ok);

    // Hold the offer back while the bank's final write is still in the pipeline.
    always_comb begin
        bus.blk_valid = 1'b0;
        if (offSel)
            bus.blk_valid = (stateB == FULL) && !(pipeBeat && pipeBank);
        else
            bus.blk_valid = (stateA == FULL) && !(pipeBeat && !pipeBank);
    end
    assign bus.blk_bank = offSel;
    assign bus.blk_len  = offSel ? lenB : lenA;
    assign take         = bus.blk_valid && bus.blk_ready;

    // With both banks draining, off_sel has wrapped back to the older one.
    assign relA = bus.blk_release && (stateA == DRAIN) && ((stateB != DRAIN) || !offSel);
    assign relB = bus.blk_release && (stateB == DRAIN) && ((stateA != DRAIN) || offSel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fillSel      <= 1'b0;
            offSel       <= 1'b0;
            wrPtr        <= '0;
            err_overflow <= 1'b0;
            pipeBeat     <= 1'b0;
            pipeBank     <= 1'b0;
            pipeWe1      <= 1'b0;
            pipeWe2      <= 1'b0;
            pipeAddr1    <= '0;
            pipeAddr2    <= '0;
            pipeData1    <= '0;
            pipeData2    <= '0;
        end else begin
            pipeBeat <= beatTake;
            pipeWe1  <= beatTake && lane0Ok;
            pipeWe2  <= beatTake && lane1Ok;
            if (beatTake) begin
                pipeBank  <= fillSel;
                pipeAddr1 <= wrPtr[ADDR_W-1:0];
                pipeAddr2 <= ptr1[ADDR_W-1:0];
                pipeData1 <= bus.in_data0;
                pipeData2 <= bus.in_data1;
                if (drop)
                    err_overflow <= 1'b1;
                if (bus.in_last) begin
                    wrPtr   <= '0;
                    fillSel <= ~fillSel;
                end else begin
                    wrPtr <= nextPtr;
                end
            end
            if (take)
                offSel <= ~offSel;
        end
    end

    indice_bank_ctrl #(.K(K)) u_bankA (
        .clk(clk), .rst_n(rst_n),
        .startFill(!anyFill && !fillSel), .setFull(lastTake && !fillSel), .lenIn(nextPtr),
        .take(take && !offSel), .relIn(relA),
        .wrEn1(pipeWe1 && !pipeBank), .wrEn2(pipeWe2 && !pipeBank),
        .wrAddr1(pipeAddr1), .wrAddr2(pipeAddr2), .wrData1(pipeData1), .wrData2(pipeData2),
        .consAddr1(bus.cons_addr1), .consAddr2(bus.cons_addr2),
        .state(stateA), .len(lenA),
        .addr1(addrA1), .addr2(addrA2), .data1(dataA1), .data2(dataA2), .wen1(wenA1), .wen2(wenA2)
    );

    indice_bank_ctrl #(.K(K)) u_bankB (
        .clk(clk), .rst_n(rst_n),
        .startFill(!anyFill && fillSel), .setFull(lastTake && fillSel), .lenIn(nextPtr),
        .take(take && offSel), .relIn(relB),
        .wrEn1(pipeWe1 && pipeBank), .wrEn2(pipeWe2 && pipeBank),
        .wrAddr1(pipeAddr1), .wrAddr2(pipeAddr2), .wrData1(pipeData1), .wrData2(pipeData2),
        .consAddr1(bus.cons_addr1), .consAddr2(bus.cons_addr2),
        .state(stateB), .len(lenB),
        .addr1(addrB1), .addr2(addrB2), .data1(dataB1), .data2(dataB2), .wen1(wenB1), .wen2(wenB2)
    );

endmodule
